// File: rtl/core_wb_s.sv
// Write-back stage: waits for L1D load data, aligns/extends it and drives the register-file port.
// Optional CORE_WB_BYPASS_EN adds registered forwarding copies of the last committed write.
module core_wb_s #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_enb,
    input  logic            wb_kill,
    input  logic [XLEN-1:0] wb_alu_result_in,
    input  logic [XLEN-1:0] wb_sx_imm_in,
    input  logic [XLEN-1:0] wb_pc_4_in,
    input  logic            wb_we_in,
    input  logic [1:0]      wb_src_in,
    input  logic [2:0]      wb_sx_type_in,
    input  logic [RD_W-1:0] wb_rd_in,
    input  logic            l1d_rsp_val_in,
    input  logic [XLEN-1:0] l1d_rsp_data_in,
`ifdef CORE_WB_BYPASS_EN
    output logic            wb_bp_val_out,
    output logic [RD_W-1:0] wb_bp_rd_out,
    output logic [XLEN-1:0] wb_bp_data_out,
`endif
    output logic            wb_rf_we_out,
    output logic [RD_W-1:0] wb_rf_rd_out,
    output logic [XLEN-1:0] wb_rf_data_out,
    output logic            wb_stall_out,
    output logic            wb_err_out
);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e          state_q;
    logic            cap_we_q;
    logic [RD_W-1:0] cap_rd_q;
    logic [2:0]      cap_sx_q;
    logic [1:0]      cap_off_q;

    logic            capture;
    logic            cap_load;
    logic            commit_we;
    logic [RD_W-1:0] commit_rd;
    logic [XLEN-1:0] commit_data;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] load_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign wb_stall_out = (state_q != StIdle);
    assign capture      = wb_enb && !wb_stall_out && !wb_kill;
    assign cap_load     = capture && (wb_src_in == 2'b01);

    always_comb begin
        src_data = wb_alu_result_in;
        unique case (wb_src_in)
            2'b00:   src_data = wb_alu_result_in;
            2'b10:   src_data = wb_pc_4_in;
            2'b11:   src_data = wb_sx_imm_in;
            default: src_data = wb_alu_result_in;
        endcase
    end

    // Response word is aligned; the latched address offset picks the lane.
    always_comb begin
        ld_byte   = l1d_rsp_data_in[{cap_off_q, 3'b000} +: 8];
        ld_half   = l1d_rsp_data_in[{cap_off_q[1], 4'b0000} +: 16];
        load_data = l1d_rsp_data_in;
        case (cap_sx_q)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = l1d_rsp_data_in;
        endcase
    end

    always_comb begin
        commit_we   = 1'b0;
        commit_rd   = wb_rd_in;
        commit_data = src_data;
        if (state_q == StIdle) begin
            commit_we = capture && !cap_load && wb_we_in && (wb_rd_in != '0);
        end else if (state_q == StWait) begin
            commit_we   = l1d_rsp_val_in && !wb_kill && cap_we_q && (cap_rd_q != '0);
            commit_rd   = cap_rd_q;
            commit_data = load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cap_we_q       <= 1'b0;
            cap_rd_q       <= '0;
            cap_sx_q       <= '0;
            cap_off_q      <= '0;
            wb_rf_we_out   <= 1'b0;
            wb_rf_rd_out   <= '0;
            wb_rf_data_out <= '0;
            wb_err_out     <= 1'b0;
        end else begin
            wb_rf_we_out <= commit_we;
            if (commit_we) begin
                wb_rf_rd_out   <= commit_rd;
                wb_rf_data_out <= commit_data;
            end
            if (state_q == StIdle && l1d_rsp_val_in) begin
                wb_err_out <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (cap_load) begin
                        cap_we_q  <= wb_we_in;
                        cap_rd_q  <= wb_rd_in;
                        cap_sx_q  <= wb_sx_type_in;
                        cap_off_q <= wb_alu_result_in[1:0];
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (l1d_rsp_val_in)   state_q <= StIdle;
                    else if (wb_kill)     state_q <= StDrain;
                end
                StDrain: begin
                    if (l1d_rsp_val_in)   state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CORE_WB_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_bp_val_out  <= 1'b0;
            wb_bp_rd_out   <= '0;
            wb_bp_data_out <= '0;
        end else if (commit_we) begin
            wb_bp_val_out  <= 1'b1;
            wb_bp_rd_out   <= commit_rd;
            wb_bp_data_out <= commit_data;
        end else if (wb_kill) begin
            wb_bp_val_out  <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/core_wb_s.md
Name: core_wb_s

Overview:
- Write-back stage of the core pipeline, directly downstream of the memory stage.
- Consumes the memory stage's registered results (ALU result, sign-extended immediate, PC+4, write enable, source select, load extension type, rd).
- Waits for the L1D load response, aligns and sign/zero-extends the loaded data, and selects the write-back value.
- Drives the register-file write port and stalls the pipeline while a load is outstanding.

Parameters:
- XLEN, 32, data/address width.
- RD_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wb_enb  in  1  pipeline advance; capture inputs when high and stage not stalled.
- wb_kill  in  1  flush current instruction.
- wb_alu_result_in  in  XLEN  ALU result / load address.
- wb_sx_imm_in  in  XLEN  sign-extended immediate.
- wb_pc_4_in  in  XLEN  PC+4.
- wb_we_in  in  1  instruction writes the register file.
- wb_src_in  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 imm.
- wb_sx_type_in  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- wb_rd_in  in  RD_W  destination register.
- l1d_rsp_val_in  in  1  L1D load response valid.
- l1d_rsp_data_in  in  XLEN  L1D read word (aligned word).
- wb_rf_we_out  out  1  register-file write enable (registered).
- wb_rf_rd_out  out  RD_W  write index (registered).
- wb_rf_data_out  out  XLEN  write data (registered).
- wb_stall_out  out  1  stall upstream (combinational from state).
- wb_err_out  out  1  sticky: unexpected L1D response.

Behaviour:
- Reset (rst high, async): all outputs 0; FSM in IDLE; capture registers cleared.
- Stall: wb_stall_out = (state != IDLE). Capture happens only when wb_enb=1 and wb_stall_out=0; wb_enb is ignored while stalled.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE, capture with wb_src_in=01: latch fields, go to WAIT. No write that cycle.
  - IDLE, capture non-load: on the next edge wb_rf_we_out = wb_we_in & (rd != 0), with data selected per wb_src_in. Single-cycle pulse; state stays IDLE.
  - WAIT, l1d_rsp_val_in=1: extend data; next edge wb_rf_we_out=1 (if we & rd != 0) for one cycle; go to IDLE.
  - WAIT, wb_kill=1 without response: go to DRAIN, no write.
  - WAIT, wb_kill and l1d_rsp_val_in in the same cycle: response consumed, no write, go to IDLE.
  - DRAIN, l1d_rsp_val_in=1: discard, go to IDLE.
  - DRAIN ignores wb_kill.
- Earliest response is one cycle after capture. A response arriving the same cycle as capture is treated as unexpected.
- wb_kill in IDLE: discards the capture happening that cycle (no write next cycle). wb_kill takes priority over wb_enb.
- l1d_rsp_val_in in IDLE: ignored; wb_err_out set to 1 until reset.
- Extension uses offset = wb_alu_result_in[1:0] latched at capture:
  - LB/LBU select byte[offset].
  - LH/LHU select half[offset[1]], offset[0] ignored.
  - LW uses the full word.
  - Sign extension from bit 7/15; LBU/LHU zero-extend.
  - Undefined sx_type codes behave as LW.
- wb_rf_we_out is never high for rd=0; wb_rf_rd_out/wb_rf_data_out hold their last value when we=0.

Optional Feature:
- CORE_WB_BYPASS_EN.
- Defined: adds outputs wb_bp_val_out (1), wb_bp_rd_out (RD_W), wb_bp_data_out (XLEN). These are registered copies of the last committed write, updated on every wb_rf_we_out pulse and held otherwise; wb_bp_val_out is cleared by reset and by wb_kill. Used for forwarding to the memory/execute stages.
- Undefined: ports absent; no extra registers.

Test Plan:
- ALU write: capture src=00, alu=0x0000_1234, rd=5, we=1 -> next cycle we=1, rd=5, data=0x0000_1234, one cycle only.
- LB sign: capture load, sx=000, addr=0x...02; response data=0x11_80_22_33 two cycles later -> stall high for 2 cycles, then data=0xFFFF_FF80.
- LHU offset: sx=101, addr offset=2, rsp=0xBEEF_0001 -> data=0x0000_BEEF; same with sx=001 -> 0xFFFF_BEEF.
- Kill in WAIT: kill before response -> DRAIN, stall stays high; response arrives -> no write, IDLE, stall low next cycle.
- Stray response in IDLE plus rd=0: rsp_val with no load -> wb_err_out=1 and stays; ALU write with rd=0 -> we stays 0.
- Reset mid-load: assert rst in WAIT -> outputs 0, IDLE; later response -> ignored, err=1.
